// File: rtl/toom_mul_seq.sv
// toom_mul_seq: limb-serial WIDTH x WIDTH multiplier, one LIMB x LIMB product per cycle.
// Define MULSEQ_SIGNED_EN to add the signed_mode port and the NEG (two's-complement) state.
module toom_mul_seq #(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
`ifdef MULSEQ_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N  = WIDTH / LIMB;
  localparam int AW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef MULSEQ_SIGNED_EN
  typedef enum logic [1:0] {IDLE, MUL, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     product_q;
  logic [CW-1:0]     i_q, j_q;
  logic [LIMB-1:0]   a_limb, b_limb;
  logic [2*LIMB-1:0] pp;
  logic [31:0]       shamt;
  logic              last_step;
`ifdef MULSEQ_SIGNED_EN
  logic              sign_q;
`endif

  assign last_step = (i_q == LAST) && (j_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = MUL;
`ifdef MULSEQ_SIGNED_EN
      MUL:  if (last_step) state_d = NEG;
      NEG:  state_d = DONE;
`else
      MUL:  if (last_step) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from the state register
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    product   = product_q;
  end

  // One partial product per cycle, zero-extended and shifted into place
  always_comb begin
    a_limb = a_q[int'(i_q)*LIMB +: LIMB];
    b_limb = b_q[int'(j_q)*LIMB +: LIMB];
    pp     = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
    shamt  = 32'((int'(i_q) + int'(j_q)) * LIMB);
    acc_d  = acc_q + (AW'(pp) << shamt);
  end

  // Operand capture, accumulation, limb counters and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
`ifdef MULSEQ_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
`ifdef MULSEQ_SIGNED_EN
          // Magnitudes are multiplied unsigned; the sign is reapplied in NEG.
          a_q    <= (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
          b_q    <= (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
          sign_q <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
`else
          a_q    <= a_in;
          b_q    <= b_in;
`endif
          acc_q  <= '0;
          i_q    <= '0;
          j_q    <= '0;
        end
        MUL: begin
          acc_q <= acc_d;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
`ifndef MULSEQ_SIGNED_EN
          if (last_step) product_q <= acc_d;
`endif
        end
`ifdef MULSEQ_SIGNED_EN
        NEG: begin
          acc_q     <= sign_q ? (~acc_q + 1'b1) : acc_q;
          product_q <= sign_q ? (~acc_q + 1'b1) : acc_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toom_mul_seq.sv
// Self-checking bench for toom_mul_seq (default WIDTH=1024, LIMB=256).
module tb_toom_mul_seq;

  localparam int W  = 1024;
  localparam int L  = 256;
  localparam int N  = W / L;
  localparam int AW = 2 * W;
`ifdef MULSEQ_SIGNED_EN
  localparam int LAT = N * N + 1;   // edges from accept edge to first out_valid cycle
`else
  localparam int LAT = N * N;
`endif
  localparam int PER = LAT + 2;     // accept-to-accept with out_ready high

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
`ifdef MULSEQ_SIGNED_EN
  logic          signed_mode;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] product;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  toom_mul_seq #(.WIDTH(W), .LIMB(L)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_in(a_in),
    .b_in(b_in),
`ifdef MULSEQ_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sm);
    logic [AW-1:0] ea, eb;
    ea = {{W{sm & a[W-1]}}, a};
    eb = {{W{sm & b[W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int unsigned w = 0; w < W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h", tag,
             obs[AW-1 -: 64], obs[63:0], exp[AW-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair, push its expected product, return the accept edge number.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                      output int k);
    int t = 0;
    while (in_ready !== 1'b1 && t < 200) begin tick(); t++; end
    chk1("in_ready_before_send", in_ready, 1'b1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
`ifdef MULSEQ_SIGNED_EN
    signed_mode = sm;
`endif
    exp_q.push_back(model(a, b, sm));
    tick();
    k        = cyc;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, check latency and the scoreboard head.
  task automatic recv(input int k, input string tag, input logic chk_busy);
    int t = 0;
    logic [AW-1:0] e;
    while (out_valid !== 1'b1 && t < 200) begin
      if (chk_busy) begin
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_in_ready_low"}, in_ready, 1'b0);
      end
      tick();
      t++;
    end
    chki({tag, "_latency"}, cyc - k, LAT);
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_scoreboard: observed empty queue, expected a pending result", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_product"}, product, e);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int k, kprev, ov_seen;
    logic [AW-1:0] held, c;
    logic [W-1:0] ra, rb;
    logic rs;

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
`ifdef MULSEQ_SIGNED_EN
    signed_mode = 1'b0;
`endif
    tick(); tick(); tick();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_product", product, '0);
    rst = 1'b0;
    #1;
    chk1("release_in_ready", in_ready, 1'b1);

    // Basic unsigned 3 x 5
    send(W'(3), W'(5), 1'b0, k);
    recv(k, "basic", 1'b1);
    chk("basic_const", product, AW'(15));
    consume();
    chk1("basic_idle_out_valid", out_valid, 1'b0);
    chk1("basic_idle_busy", busy, 1'b0);

    // Maximum operands: carries ripple across every limb boundary
    send('1, '1, 1'b0, k);
    recv(k, "max", 1'b0);
    c = '0 - (AW'(1) << (W + 1)) + AW'(1);
    chk("max_formula", product, c);
    consume();

    // Output backpressure with ignored in_valid pulses
    send({32{32'hdeadbeef}}, {16{64'h0123456789abcdef}}, 1'b0, k);
    recv(k, "bp", 1'b0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a_in = W'(1);
      b_in = W'(1);
      tick();
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_product_stable", product, held);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    consume();
    chk1("bp_release_in_ready", in_ready, 1'b1);
    chk1("bp_release_out_valid", out_valid, 1'b0);
    send(W'(11), W'(13), 1'b0, k);
    recv(k, "bp_next", 1'b0);
    chk("bp_next_const", product, AW'(143));
    consume();

    // Reset in the middle of MUL
    send(W'(100), W'(200), 1'b0, k);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_product", product, '0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk1("mid_rst_release_in_ready", in_ready, 1'b1);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) ov_seen++;
    end
    chki("mid_rst_no_out_valid", ov_seen, 0);
    send(W'(7), W'(9), 1'b0, k);
    recv(k, "after_rst", 1'b0);
    chk("after_rst_const", product, AW'(63));
    consume();

`ifdef MULSEQ_SIGNED_EN
    // Signed directed cases
    send('1, W'(2), 1'b1, k);
    recv(k, "s_m1x2", 1'b1);
    chk("s_m1x2_const", product, '0 - AW'(2));
    consume();
    ra = '0; ra[W-1] = 1'b1;
    send(ra, ra, 1'b1, k);
    recv(k, "s_minsq", 1'b0);
    chk("s_minsq_const", product, AW'(1) << (AW - 2));
    consume();
    send('1, W'(2), 1'b0, k);
    recv(k, "s_unsigned", 1'b0);
    chk("s_unsigned_const", product, (AW'(1) << (W + 1)) - AW'(2));
    consume();
`endif

    // Back-to-back random pairs with out_ready tied high
    out_ready = 1'b1;
    kprev = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = rnd();
      rb = rnd();
      if (i % 97 == 0) ra = '1;
      if (i % 89 == 0) rb = '0;
      rs = 1'b0;
`ifdef MULSEQ_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`endif
      send(ra, rb, rs, k);
      if (i > 0) chki("rand_period", k - kprev, PER);
      kprev = k;
      recv(k, "rand", 1'b0);
      tick();
    end
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toom_mul_seq.md
# toom_mul_seq

Parametrised, limb-serial large-integer multiplier for the wide-arithmetic datapath. It sits where area matters more than throughput, alongside the fully combinational 1024-bit multiplier. Each accepted operand pair is split into N = WIDTH/LIMB limbs, and one LIMB×LIMB product is accumulated per cycle. Both sides use valid/ready handshakes, and an optional two's-complement mode is compiled in by macro.

## Interface
- WIDTH, 1024: operand width in bits; must be a multiple of LIMB.
- LIMB, 256: limb width; the single hardware multiplier is LIMB×LIMB. N = WIDTH/LIMB ≥ 1.

Ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept; high only in IDLE and while rst low.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- signed_mode  in  1  sampled with operands; present only with MULSEQ_SIGNED_EN.
- out_valid  out  1  product valid; held until accepted.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result; stable while out_valid high.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, NEG (only with MULSEQ_SIGNED_EN), DONE.
- IDLE → MUL on in_valid && in_ready.
  - Captures operands.
  - Clears the accumulator to 0.
  - Clears limb counters i = 0 and j = 0.
- MUL performs one step per cycle:
  - acc += (a_limb[i] * b_limb[j]) << ((i+j)*LIMB).
  - j is the inner counter and i the outer counter.
  - The 2*LIMB partial product is zero-extended to 2*WIDTH.
  - Accumulator arithmetic is modulo 2^(2*WIDTH); overflow is impossible for legal operands.
  - Ends after exactly N*N steps, on the step with i = j = N-1.
- MUL → NEG when the macro is defined; otherwise MUL → DONE.
- NEG: if the captured sign flag is set, acc ← (~acc + 1) mod 2^(2*WIDTH); otherwise acc is unchanged. Exactly one cycle, always visited.
- DONE: out_valid = 1 and product = acc. On out_ready the block returns to IDLE at that edge.
- No overlap: a new operand cannot be accepted in the cycle a result is consumed.
- in_valid while not in IDLE is ignored; operands are not queued.
- N = 1 is legal: MUL lasts one cycle.
- Reset, at any time including mid-MUL or mid-DONE:
  - State goes to IDLE.
  - out_valid = 0, product = 0, accumulator = 0, counters = 0, sign flag = 0, busy = 0.
  - Any in-flight operation is discarded; no out_valid is produced for it.
  - in_ready is 0 while rst is high and 1 in the first cycle after release.

## Timing
Let k be the accept edge.
- Cycles k+1 through k+N*N are in MUL.
- Unsigned build: DONE, with out_valid high, from cycle k+N*N+1.
- Signed build: NEG at k+N*N+1, DONE from k+N*N+2.
- Latency is independent of operand values and of signed_mode.
- Minimum issue period with out_ready tied high:
  - Unsigned build: N*N+2 cycles; default 18.
  - Signed build: N*N+3 cycles; default 19.
- Outputs are registered; in_ready and busy decode directly from the state register.
- product changes only on the DONE-entry edge and on reset.

## Configuration
- MULSEQ_SIGNED_EN defined:
  - The signed_mode port exists.
  - When signed_mode = 1 at accept, a_in and b_in are two's complement.
  - The block stores |a| and |b| as WIDTH-bit unsigned values (−2^(WIDTH−1) maps to 2^(WIDTH−1)) and stores sign = a_msb ^ b_msb.
  - The NEG state is present.
  - product is the 2*WIDTH two's-complement result.
  - When signed_mode = 0, the result is unsigned, the sign flag is 0, and the NEG cycle is still spent.
- MULSEQ_SIGNED_EN undefined:
  - No signed_mode port and no NEG state.
  - Unsigned only.
  - Latency is N*N+1 cycles.

## Test plan
All scenarios use WIDTH=1024, LIMB=256.
- Basic unsigned: reset, then a_in=3, b_in=5 → out_valid at accept+17, product=15; in_ready=0 and busy=1 throughout cycles accept+1 to accept+17.
- Maximum operands: a_in=b_in=2^1024−1 → product=2^2048−2^1025+1; check the accumulator carry across every limb boundary.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid → product and out_valid stable, in_ready=0, and in_valid pulses are ignored; raise out_ready → IDLE next cycle, and the next operands are accepted.
- Reset mid-operation: assert rst at MUL step 8 → out_valid stays 0, product=0, in_ready=1 on the first cycle after release; a following 7×9 returns 63.
- Signed build: signed_mode=1 with the following pairs, each with latency 18 cycles:
  - a=−1, b=2 → product=2^2048−2.
  - a=−2^1023, b=−2^1023 → product=2^2046.
  - signed_mode=0 with a=2^1024−1, b=2 → product=2^1025−2.
- Back-to-back random: 1000 random pairs, out_ready tied to 1 → each product matches the golden big-integer model; the accept-to-accept period is exactly 18 cycles, or 19 in the signed build.
